// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
package fetch_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int DEPTH_DEF = 4;
  localparam int PTR_W     = $clog2(DEPTH_DEF) + 1;

  // Canonical NOP (addi x0, x0, 0) that decode can insert as a bubble.
  localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              filled;
  } fetch_entry_t;

  // Pointers carry one extra bit beyond the index so full and empty differ.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/instr_fetch_queue.sv
// Issues instruction-memory reads for the current PC and holds returned
// instructions, tagged with their PCs, in an in-order queue for decode.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  flush,
  output logic                  pc_advance,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc
);

  localparam int P_W    = ptr_width(DEPTH);
  localparam int IDX_W  = P_W - 1;
  localparam int DROP_W = P_W + 1;

  logic [P_W-1:0]    alloc_ptr_reg, fill_ptr_reg, head_ptr_reg, count_reg;
  logic [DROP_W-1:0] drop_cnt_reg;

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic                  filled_reg [DEPTH];

  logic [IDX_W-1:0]  alloc_idx, fill_idx, head_idx;
  logic [P_W-1:0]    outstanding;
  logic [DROP_W-1:0] drop_flush;
  logic              full, req_fire, deq, rsp_fill, rsp_drop;

  assign alloc_idx = alloc_ptr_reg[IDX_W-1:0];
  assign fill_idx  = fill_ptr_reg[IDX_W-1:0];
  assign head_idx  = head_ptr_reg[IDX_W-1:0];

  assign full           = (count_reg == P_W'(DEPTH));
  assign imem_req_valid = !rst && !flush && !full;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign pc_advance     = req_fire;

  assign instr_valid = (count_reg != '0) && filled_reg[head_idx];
  assign instr       = data_mem[head_idx];
  assign instr_pc    = addr_mem[head_idx];
  assign deq         = instr_valid && instr_ready && !flush;

  // Responses owed to wrong-path requests are swallowed before any is stored.
  assign rsp_drop    = imem_rsp_valid && (drop_cnt_reg != '0);
  assign rsp_fill    = imem_rsp_valid && (drop_cnt_reg == '0) && !flush;
  assign outstanding = alloc_ptr_reg - fill_ptr_reg;
  assign drop_flush  = drop_cnt_reg + DROP_W'(outstanding) - DROP_W'(imem_rsp_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_ptr_reg <= '0;
      fill_ptr_reg  <= '0;
      head_ptr_reg  <= '0;
      count_reg     <= '0;
      drop_cnt_reg  <= '0;
    end else if (flush) begin
      alloc_ptr_reg <= '0;
      fill_ptr_reg  <= '0;
      head_ptr_reg  <= '0;
      count_reg     <= '0;
      drop_cnt_reg  <= drop_flush;
    end else begin
      if (req_fire) alloc_ptr_reg <= alloc_ptr_reg + 1'b1;
      if (rsp_fill) fill_ptr_reg  <= fill_ptr_reg + 1'b1;
      if (deq)      head_ptr_reg  <= head_ptr_reg + 1'b1;
      if (rsp_drop) drop_cnt_reg  <= drop_cnt_reg - 1'b1;
      count_reg <= count_reg + P_W'(req_fire) - P_W'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) addr_mem[alloc_idx] <= pc;
    if (rsp_fill && !rst) data_mem[fill_idx] <= imem_rsp_data;
  end

  // Fill targets an allocated, unfilled slot, so set and clear never collide.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_filled
    always_ff @(posedge clk) begin
      if (rst || flush)
        filled_reg[gi] <= 1'b0;
      else if (rsp_fill && fill_idx == IDX_W'(gi))
        filled_reg[gi] <= 1'b1;
      else if ((deq && head_idx == IDX_W'(gi)) || (req_fire && alloc_idx == IDX_W'(gi)))
        filled_reg[gi] <= 1'b0;
    end
  end

  property p_no_orphan_rsp;
    @(posedge clk) disable iff (rst)
      !(imem_rsp_valid && drop_cnt_reg == '0 && outstanding == '0);
  endproperty
  a_no_orphan_rsp: assert property (p_no_orphan_rsp);

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized scoreboard bench for instr_fetch_queue with an in-bench memory and PC unit.
module tb_instr_fetch_queue;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst, flush, pc_advance, imem_req_valid, imem_req_ready;
  logic          imem_rsp_valid, instr_valid, instr_ready;
  logic [AW-1:0] pc, imem_req_addr, instr_pc;
  logic [DW-1:0] imem_rsp_data, instr;

  always #5 clk = ~clk;

  instr_fetch_queue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc(pc), .flush(flush), .pc_advance(pc_advance),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  // Expected queue content: PC and the cycle its response arrived (-1 = pending).
  typedef struct { logic [AW-1:0] pc; int rsp_cyc; } exp_t;
  // Memory pipeline entry: live = still owed to the current (right) path.
  typedef struct { logic [AW-1:0] addr; int due; bit live; } mem_t;

  exp_t          exp_q[$];
  mem_t          mem_q[$];
  int            cyc = 0;
  int            vectors = 0;
  int            miscompares = 0;
  int            lat = 1;
  int            p_req_rdy = 100;
  int            p_instr_rdy = 100;
  int            p_flush = 0;
  bit            rst_prev = 1'b0;
  logic [AW-1:0] pc_model = '0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0013;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h required %h", name, cyc, act, req);
    end
  endtask

  // One clock of stimulus; the model is advanced after the monitor has checked.
  task automatic step(input bit f, input logic [AW-1:0] tgt, input bit r);
    mem_t m;
    @(negedge clk);
    cyc++;
    rst            = r;
    flush          = f;
    imem_req_ready = ($urandom_range(99) < p_req_rdy);
    instr_ready    = ($urandom_range(99) < p_instr_rdy);
    pc             = pc_model;
    if (!r && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #3;
    if (r) begin
      exp_q.delete();
      mem_q.delete();
      pc_model = tgt;
    end else begin
      if (imem_rsp_valid) begin
        m = mem_q.pop_front();
        if (m.live && !f) begin
          for (int i = 0; i < exp_q.size(); i++)
            if (exp_q[i].rsp_cyc < 0) begin
              exp_q[i].rsp_cyc = cyc;
              break;
            end
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        exp_q.push_back('{imem_req_addr, -1});
        mem_q.push_back('{imem_req_addr, cyc + lat, 1'b1});
      end
      if (pc_advance) pc_model = pc_model + 4;
      if (f) begin
        exp_q.delete();
        foreach (mem_q[i]) mem_q[i].live = 1'b0;
        pc_model = tgt;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(99) < p_flush) step(1'b1, $urandom & 32'hFFFF_FFFC, 1'b0);
      else step(1'b0, '0, 1'b0);
    end
  endtask

  // Monitor: compares DUT outputs against the model state of the current cycle.
  initial begin
    exp_t e;
    bit   exp_iv, exp_rv;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        if (rst_prev) begin
          chk("rst_instr_valid", instr_valid, 1'b0);
          chk("rst_req_valid", imem_req_valid, 1'b0);
          chk("rst_pc_advance", pc_advance, 1'b0);
        end
      end else begin
        exp_rv = !flush && (exp_q.size() < DEPTH);
        chk("req_valid", imem_req_valid, exp_rv);
        chk("pc_advance", pc_advance, exp_rv && imem_req_ready);
        if (imem_req_valid) chk("req_addr", imem_req_addr, pc);
        exp_iv = (exp_q.size() > 0) && (exp_q[0].rsp_cyc >= 0) && (exp_q[0].rsp_cyc < cyc);
        chk("instr_valid", instr_valid, exp_iv);
        if (instr_valid && instr_ready && !flush) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL spurious_instr cycle %0d: got pc %h, required no entry", cyc, instr_pc);
          end else begin
            e = exp_q.pop_front();
            chk("instr_pc", instr_pc, e.pc);
            chk("instr", instr, mem_word(e.pc));
            $display("deq cycle %0d pc=%h instr=%h", cyc, instr_pc, instr);
          end
        end
      end
      rst_prev = rst;
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; pc = '0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; instr_ready = 1'b0;

    // Reset, then 1-cycle memory with decode always ready.
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    lat = 1; p_req_rdy = 100; p_instr_rdy = 100; p_flush = 0;
    run(12);

    // Decode stalled: queue fills to DEPTH, then one accept frees one slot.
    p_instr_rdy = 0;
    run(8);
    p_instr_rdy = 100;
    run(1);
    p_instr_rdy = 0;
    run(4);

    // 3-cycle memory, two outstanding requests, then redirect to 0x100.
    step(1'b0, '0, 1'b1);
    lat = 3; p_instr_rdy = 100;
    run(2);
    step(1'b1, 32'h0000_0100, 1'b0);
    run(12);

    // Flush coinciding with a response and a dequeue.
    lat = 1;
    run(6);
    step(1'b1, 32'h0000_0200, 1'b0);
    run(6);

    // Memory request port toggling.
    p_req_rdy = 50;
    run(30);

    // Reset with entries buffered and requests outstanding.
    p_req_rdy = 100; p_instr_rdy = 0; lat = 2;
    run(5);
    step(1'b0, 32'h0000_0040, 1'b1);
    step(1'b0, 32'h0000_0040, 1'b1);
    p_instr_rdy = 100;
    run(10);

    // Randomized operation.
    for (int k = 0; k < 20; k++) begin
      lat         = $urandom_range(1, 4);
      p_req_rdy   = $urandom_range(30, 100);
      p_instr_rdy = $urandom_range(20, 100);
      p_flush     = $urandom_range(0, 8);
      if ($urandom_range(9) == 0) step(1'b0, $urandom & 32'hFFFF_FFFC, 1'b1);
      run(100);
    end

    // Drain: stop requests and confirm every right-path instruction came out.
    p_req_rdy = 0; p_instr_rdy = 100; p_flush = 0;
    run(20);
    chk("drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
